seq_multiplier: RTL



---
 rtl/seq_multiplier.sv | 139 +++++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add unsigned multiplier, one partial product per clock.
// Ports:
//   clk, rst (sync, active-high)
//   start, a, b  -> request a multiply with operands a and b
//   busy         -> high during the WIDTH accumulate cycles
//   done         -> one-cycle pulse when product updates
//   product      -> 2*WIDTH result, held until the next result
//   seg_lo/seg_hi -> hex digits of product[3:0]/[7:4] (SEG7_HEX_EN only)
// Optional feature macro: SEG7_HEX_EN.
module seq_multiplier #(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
`ifdef SEG7_HEX_EN
    ,
    output logic [6:0]         seg_lo,
    output logic [6:0]         seg_hi
`endif
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;

`ifdef SEG7_HEX_EN
    // Pad so the upper nibble exists even for narrow products.
    logic [PW+7:0] acc_ext;
    assign acc_ext = {8'd0, acc};

    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] s;
        s = 7'h00;
        unique case (d)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
`ifdef SEG7_HEX_EN
            seg_lo  <= 7'b0111111;
            seg_hi  <= 7'b0111111;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    product <= acc;
                    done    <= 1'b1;
`ifdef SEG7_HEX_EN
                    seg_lo  <= hex7(acc_ext[3:0]);
                    seg_hi  <= hex7(acc_ext[7:4]);
`endif
                    // Back-to-back: acc is read above before being cleared.
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
